// File: rtl/aes_uart_pkg.sv
// Shared types and helpers for the UART-to-AES plaintext path.
// Byte 0 of a block always sits in bits [127:120].
package aes_uart_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        PAD_BLK = 2'd2
    } asm_state_t;

    localparam int AES_BLOCK_BYTES = 16;
    localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;

    function automatic logic [127:0] setByte(input logic [127:0] blk,
                                             input logic [3:0]   idx,
                                             input logic [7:0]   val);
        logic [127:0] res;
        res = blk;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (idx == 4'(i)) begin
                res[127-8*i -: 8] = val;
            end
        end
        return res;
    endfunction

    // Bytes at positions >= keep are overwritten with padVal.
    function automatic logic [127:0] padBlock(input logic [127:0] blk,
                                              input logic [4:0]   keep,
                                              input logic [7:0]   padVal);
        logic [127:0] res;
        res = blk;
        for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
            if (5'(i) >= keep) begin
                res[127-8*i -: 8] = padVal;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/my_axis_if.sv
// Minimal AXI-Stream bundle; DATA_W selects the byte or block width.
interface my_axis_if #(parameter int DATA_W = 8);

    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tready;
    logic                tlast;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);

endinterface

// File: rtl/aes_block_assembler_idle_timer.sv
// Idle counter for partial-block flushing; Expired is a single-cycle pulse.
// With TIMEOUT_CYCLES == 0 the timer is tied off entirely.
module idle_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    input  logic Run,
    output logic Expired
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : gTimer
            localparam int W = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

            logic [W-1:0] idleCnt;

            // Wraps to zero on expiry so a stuck Run cannot overflow the counter.
            always_ff @(posedge Clk) begin
                if (Rst || Clear) begin
                    idleCnt <= '0;
                end else if (Run) begin
                    idleCnt <= (idleCnt == LAST) ? '0 : idleCnt + W'(1);
                end
            end

            assign Expired = Run && (idleCnt == LAST);
        end else begin : gNoTimer
            logic unusedInputs;
            assign unusedInputs = ^{Clk, Rst, Clear, Run};
            assign Expired = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/aes_block_assembler.sv
// Packs the UART plaintext byte stream into 128-bit blocks, first byte as MSB.
// Define AES_ASM_PKCS7_EN for PKCS#7 padding (otherwise zero padding).
module aes_block_assembler
    import aes_uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic      Clk,
    input  logic      Rst,
    input  logic      En,
    my_axis_if.slave  s_axis,
    my_axis_if.master m_axis,
    output logic      TimeoutFlush
);

    asm_state_t   stateReg;
    logic [127:0] bufReg;
    logic [3:0]   byteCnt;
    logic         lastReg;
    logic         validReg;
    logic         flushReg;
`ifdef AES_ASM_PKCS7_EN
    logic         padPending;
`endif

    logic         clr;
    logic         accept;
    logic         timerRun;
    logic         expired;
    logic [127:0] withByte;
    logic [4:0]   cntNow;
    logic [4:0]   cntPlusOne;
    logic [7:0]   padOnLast;
    logic [7:0]   padOnTimeout;
    logic         unusedKeep;

    assign clr        = Rst || !En;
    assign accept     = s_axis.tvalid && s_axis.tready;
    assign cntNow     = {1'b0, byteCnt};
    assign cntPlusOne = {1'b0, byteCnt} + 5'd1;
    assign unusedKeep = ^s_axis.tkeep;

`ifdef AES_ASM_PKCS7_EN
    assign padOnLast    = {3'b000, 5'd16 - cntPlusOne};
    assign padOnTimeout = {3'b000, 5'd16 - cntNow};
`else
    assign padOnLast    = 8'h00;
    assign padOnTimeout = 8'h00;
`endif

    always_comb begin
        withByte = setByte(bufReg, byteCnt, s_axis.tdata);
    end

    // An accept on the would-be expiry cycle drops Run, so the byte wins.
    assign timerRun = (stateReg == FILL) && !accept && (byteCnt != 4'd0);

    idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uIdleTimer (
        .Clk     (Clk),
        .Rst     (clr),
        .Clear   (!timerRun),
        .Run     (timerRun),
        .Expired (expired)
    );

    assign s_axis.tready = En && !Rst && (stateReg == FILL);
    assign m_axis.tdata  = bufReg;
    assign m_axis.tvalid = validReg;
    assign m_axis.tlast  = lastReg;
    assign m_axis.tkeep  = '1;
    assign TimeoutFlush  = flushReg;

    always_ff @(posedge Clk) begin
        if (clr) begin
            stateReg   <= FILL;
            bufReg     <= '0;
            byteCnt    <= '0;
            lastReg    <= 1'b0;
            validReg   <= 1'b0;
            flushReg   <= 1'b0;
`ifdef AES_ASM_PKCS7_EN
            padPending <= 1'b0;
`endif
        end else begin
            flushReg <= 1'b0;
            case (stateReg)
                FILL: begin
                    if (accept) begin
                        byteCnt <= byteCnt + 4'd1;
                        if (byteCnt == 4'd15) begin
                            // A full block never gets padded, even when it ends the message.
                            bufReg   <= withByte;
                            validReg <= 1'b1;
                            stateReg <= HOLD;
`ifdef AES_ASM_PKCS7_EN
                            lastReg    <= 1'b0;
                            padPending <= s_axis.tlast;
`else
                            lastReg    <= s_axis.tlast;
`endif
                        end else if (s_axis.tlast) begin
                            bufReg   <= padBlock(withByte, cntPlusOne, padOnLast);
                            lastReg  <= 1'b1;
                            validReg <= 1'b1;
                            stateReg <= HOLD;
                        end else begin
                            bufReg <= withByte;
                        end
                    end else if (expired) begin
                        bufReg   <= padBlock(bufReg, cntNow, padOnTimeout);
                        lastReg  <= 1'b1;
                        flushReg <= 1'b1;
                        validReg <= 1'b1;
                        stateReg <= HOLD;
                    end
                end
                HOLD: begin
                    if (m_axis.tready) begin
                        bufReg   <= '0;
                        byteCnt  <= '0;
                        lastReg  <= 1'b0;
                        validReg <= 1'b0;
`ifdef AES_ASM_PKCS7_EN
                        stateReg <= padPending ? PAD_BLK : FILL;
`else
                        stateReg <= FILL;
`endif
                    end
                end
`ifdef AES_ASM_PKCS7_EN
                PAD_BLK: begin
                    bufReg     <= {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
                    lastReg    <= 1'b1;
                    padPending <= 1'b0;
                    validReg   <= 1'b1;
                    stateReg   <= HOLD;
                end
`endif
                default: begin
                    stateReg <= FILL;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_block_assembler.md
# aes_block_assembler

Upstream feeder for the AES cipher: collects the 8-bit plaintext byte stream from the UART RX path into 128-bit blocks and hands each block over a 128-bit AXI-Stream to the cipher's plaintext input. The first received byte becomes the block MSB, bits [127:120], matching the cipher's MSB-first ciphertext serialisation. Partial blocks are padded and flushed on `tlast` or after an idle timeout, so a short message is never stranded in the buffer.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 100000: idle cycles before a partial block is flushed. 0 disables the timeout.

Ports:
- `Clk`, input, 1: clock.
- `Rst`, input, 1: reset; synchronous, active-high.
- `En`, input, 1: block enable. Low acts as a synchronous clear, identical to `Rst`.
- `s_axis`, `my_axis_if.slave`, 8: plaintext bytes. Uses `tdata`, `tvalid`, `tready` and `tlast`; `tkeep` is ignored.
- `m_axis`, `my_axis_if.master`, 128: plaintext blocks to the cipher. Uses `tdata`, `tvalid`, `tready` and `tlast`; `tkeep` is driven all ones.
- `TimeoutFlush`, output, 1: one-cycle pulse when a block is closed by the timeout.

## Operation
- Register state: `Buf[127:0]`, `ByteCnt[3:0]`, `IdleCnt`, `PadPending`, `LastReg`, `StateReg`.
- State machine with three states: `FILL`, `HOLD`, `PAD_BLK`.
- `FILL` state:
  - `s_axis.tready` = `En`.
  - On accept, the byte is written to `Buf[127-8*ByteCnt -: 8]`, `ByteCnt` increments, and `IdleCnt` clears.
  - Accept with `ByteCnt==15`: go to `HOLD`; `LastReg` = `tlast`; `PadPending` = `tlast` (PKCS7 build only).
  - Accept with `tlast` and `ByteCnt<15`: fill the remaining bytes with the pad value, go to `HOLD`, set `LastReg`=1.
  - No accept, `ByteCnt!=0`, timeout enabled: `IdleCnt` increments.
    - When `IdleCnt` reaches `TIMEOUT_CYCLES-1`: pad the block, set `LastReg`=1, pulse `TimeoutFlush`, go to `HOLD`.
  - While `ByteCnt==0`, `IdleCnt` is held at 0.
- `HOLD` state:
  - `s_axis.tready`=0.
  - `m_axis.tvalid`=1, `tdata`=`Buf`, `tlast`=`LastReg`.
  - `tdata` and `tlast` stay stable until `tready`.
  - On `tready`: clear `Buf`, `ByteCnt` and `LastReg`.
    - If `PadPending`, go to `PAD_BLK`.
    - Otherwise go to `FILL`.
- `PAD_BLK` state:
  - Load `Buf` with 16 × 0x10, set `LastReg`=1, clear `PadPending`, go to `HOLD`.
  - `s_axis.tready`=0.
- Pad value: 0x00 by default; under the PKCS7 macro it is `16-N`, where N is the number of received bytes in the block.
- Simultaneous events:
  - A byte accepted on the same cycle the timeout would fire wins; the counter clears and no flush occurs.
  - `tlast` on the 16th byte is handled as a full block, never as a partial one.
- Reset or `En` low mid-block: the partial block is discarded with no output, and the block returns to `FILL` with everything cleared.

## Timing
- Reset values: `s_axis.tready`=0 while in reset (it is 1 in `FILL` once `En`=1), `m_axis.tvalid`=0, `m_axis.tdata`=0, `m_axis.tlast`=0, `m_axis.tkeep`=all ones, `TimeoutFlush`=0. State is `FILL`.
- Latency: `m_axis.tvalid` rises on the cycle after the 16th byte (or `tlast`) is accepted.
- Timeout flush: `tvalid` rises the cycle after `IdleCnt` reaches `TIMEOUT_CYCLES-1`.
- `HOLD` exits on the cycle after the handshake.
- Peak rate is one byte per cycle; each block costs one additional `HOLD` handshake cycle. This is far above UART byte rates.
- `PAD_BLK` adds one cycle before the extra block appears.

## Configuration
- `AES_ASM_PKCS7_EN` defined:
  - PKCS#7 padding; a short block is padded with `16-N` bytes of value `16-N`.
  - A message that ends exactly on a block boundary (`tlast` on byte 16) is followed by an extra block of 16 × 0x10 with `tlast`=1; the full block itself carries `tlast`=0.
  - Timeout flushes also use PKCS#7 padding.
- Not defined:
  - Zero padding, and no extra block.
  - `PadPending` and `PAD_BLK` are compiled out; a full block ending on `tlast` is emitted with `tlast`=1.

## Structure
- Shared package `aes_uart_pkg` holds:
  - `asm_state_t` enum, 2 bits: `FILL`=0, `HOLD`=1, `PAD_BLK`=2.
  - `AES_BLOCK_BYTES`=16.
  - `PKCS7_FULL_PAD`=8'h10.
- One sub-module, `idle_timer`: parameter `TIMEOUT_CYCLES`; inputs `Clk`, `Rst`, `Clear`, `Run`; output `Expired`, a one-cycle pulse. Width is `$clog2(TIMEOUT_CYCLES+1)`. The whole timer is tied off when `TIMEOUT_CYCLES`==0.

## Test plan
- Bytes 0x00..0x0F, `m_axis.tready`=1 → one block 128'h000102…0F; `tvalid` rises the cycle after byte 0x0F; `tlast` equals the `tlast` of byte 0x0F.
- Bytes 0xAA, 0xBB with `tlast` on 0xBB:
  - Default build → 128'hAABB0000…00, `tlast`=1.
  - PKCS7 build → 128'hAABB0E0E…0E.
- 16 bytes with `tlast` on the 16th, PKCS7 build → data block with `tlast`=0, then a block of 16 × 0x10 with `tlast`=1.
- 3 bytes then idle, `TIMEOUT_CYCLES`=50 → `TimeoutFlush` pulses 50 cycles after the last accept; the padded block is emitted with `tlast`=1.
- `m_axis.tready`=0 for 20 cycles in `HOLD` → `tdata` stable, `s_axis.tready`=0, no bytes lost; the block drains on `tready`.
- 7 bytes, then `Rst`=1 for 1 cycle, then 16 new bytes → only the new block is output; no remnants of the first 7.
